// File: rtl/gp_count_pkg.sv
// Shared types and limits for the gp_count_fsm counter macrocell model.
package gp_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam string MODE_REPEAT  = "REPEAT";
    localparam string MODE_ONESHOT = "ONESHOT";
    localparam string RV_ZERO      = "ZERO";
    localparam string RV_COUNT_TO  = "COUNT_TO";

    localparam int WIDTH_MIN  = 2;
    localparam int WIDTH_MAX  = 32;
    localparam int DIVIDE_MIN = 1;
    localparam int DIVIDE_MAX = 256;

endpackage

// File: rtl/gp_prescaler.sv
// Clock prescaler: one-cycle tick every DIVIDE enabled cycles.
// Latency: tick is combinational from the registered divider count.
// Backpressure: en low freezes the divider; clr forces it back to zero.
module gp_prescaler #(
    parameter int DIVIDE = 1
) (
    input  logic CLK,
    input  logic nRST,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            DW   = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIVIDE - 1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick = en && (div_cnt_q == LAST);

endmodule

// File: rtl/gp_count_fsm.sv
// Prescaled up/down counter with reload, REPEAT or ONESHOT (IDLE/RUN/DONE) operation.
// Latency: count and TC update one CLK after a tick; OUT is combinational from count and UP.
// Backpressure: KEEP freezes count and prescaler; a ONESHOT trigger still loads while KEEP is high.
module gp_count_fsm
    import gp_count_pkg::*;
#(
    parameter int          WIDTH        = 14,
    parameter int          POUT_WIDTH   = 8,
    parameter int unsigned COUNT_TO     = 1,
    parameter string       RESET_VALUE  = "ZERO",
    parameter int          CLKIN_DIVIDE = 1,
    parameter string       MODE         = "REPEAT"
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  UP,
    input  logic                  KEEP,
    input  logic                  TRIG,
    output logic                  OUT,
    output logic                  TC,
    output logic                  BUSY,
    output logic [POUT_WIDTH-1:0] POUT
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $fatal(1, "gp_count_fsm: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (POUT_WIDTH > WIDTH) begin : g_bad_pout
        $fatal(1, "gp_count_fsm: POUT_WIDTH %0d exceeds WIDTH %0d", POUT_WIDTH, WIDTH);
    end
    if (CLKIN_DIVIDE < DIVIDE_MIN || CLKIN_DIVIDE > DIVIDE_MAX) begin : g_bad_div
        $fatal(1, "gp_count_fsm: CLKIN_DIVIDE %0d outside %0d..%0d", CLKIN_DIVIDE, DIVIDE_MIN, DIVIDE_MAX);
    end
    if (MODE != MODE_REPEAT && MODE != MODE_ONESHOT) begin : g_bad_mode
        $fatal(1, "gp_count_fsm: unknown MODE %s", MODE);
    end
    if (RESET_VALUE != RV_ZERO && RESET_VALUE != RV_COUNT_TO) begin : g_bad_rv
        $fatal(1, "gp_count_fsm: unknown RESET_VALUE %s", RESET_VALUE);
    end

    localparam bit               IS_ONESHOT = (MODE == MODE_ONESHOT);
    localparam logic [WIDTH-1:0] RELOAD     = WIDTH'(COUNT_TO);
    localparam logic [WIDTH-1:0] RST_COUNT  = (RESET_VALUE == RV_COUNT_TO) ? RELOAD : '0;
    localparam state_t           RST_STATE  = IS_ONESHOT ? ST_IDLE : ST_RUN;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

    logic [WIDTH-1:0] term_val;
    logic             at_term;
    logic             cnt_en;
    logic             load;
    logic             tick;

    assign term_val = UP ? '1 : '0;
    assign at_term  = (count_q == term_val);
    assign cnt_en   = (state_q == ST_RUN) && !KEEP;
    // A trigger is only honoured outside RUN, so a running pass cannot be restarted.
    assign load     = IS_ONESHOT && (state_q != ST_RUN) && TRIG;

    gp_prescaler #(
        .DIVIDE (CLKIN_DIVIDE)
    ) u_prescaler (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (cnt_en),
        .clr  (load),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            state_d = ST_RUN;
            count_d = RELOAD;
        end else if (tick) begin
            if (at_term) begin
                tc_d = 1'b1;
                // ONESHOT parks on the terminal value instead of reloading.
                if (IS_ONESHOT) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = RELOAD;
                end
            end else if (UP) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RST_STATE;
            count_q <= RST_COUNT;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        OUT = 1'b0;
        case (state_q)
            ST_RUN:  OUT = at_term;
            ST_DONE: OUT = 1'b1;
            default: OUT = 1'b0;
        endcase
    end

    assign TC   = tc_q;
    assign BUSY = (state_q == ST_RUN);
    assign POUT = count_q[POUT_WIDTH-1:0];

endmodule

// File: tb/tb_gp_count_fsm.sv
// Random-stimulus bench: three gp_count_fsm configurations share inputs and are
// compared every cycle against a per-instance behavioural counter model.
module tb_gp_count_fsm;

    localparam int NI = 3;
    // 0: REPEAT  W=4 CT=3 reset=COUNT_TO div=3
    // 1: ONESHOT W=4 CT=4 reset=ZERO     div=2, POUT truncated to 3 bits
    // 2: REPEAT  W=3 CT=7 reset=COUNT_TO div=1, reload equals the up terminal
    localparam int P_W   [NI] = '{4, 4, 3};
    localparam int P_PW  [NI] = '{4, 3, 3};
    localparam int P_CT  [NI] = '{3, 4, 7};
    localparam int P_DIV [NI] = '{3, 2, 1};
    localparam int P_ONE [NI] = '{0, 1, 0};
    localparam int P_RVC [NI] = '{1, 0, 1};

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic clk = 1'b0;
    logic nrst, up, keep, trig;

    logic       out_o  [NI];
    logic       tc_o   [NI];
    logic       busy_o [NI];
    logic [3:0] pout0;
    logic [2:0] pout1;
    logic [2:0] pout2;

    int m_cnt [NI];
    int m_div [NI];
    int m_st  [NI];
    int m_tc  [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gp_count_fsm #(.WIDTH(4), .POUT_WIDTH(4), .COUNT_TO(3), .RESET_VALUE("COUNT_TO"),
                   .CLKIN_DIVIDE(3), .MODE("REPEAT")) u_dut0 (
        .CLK(clk), .nRST(nrst), .UP(up), .KEEP(keep), .TRIG(trig),
        .OUT(out_o[0]), .TC(tc_o[0]), .BUSY(busy_o[0]), .POUT(pout0));

    gp_count_fsm #(.WIDTH(4), .POUT_WIDTH(3), .COUNT_TO(4), .RESET_VALUE("ZERO"),
                   .CLKIN_DIVIDE(2), .MODE("ONESHOT")) u_dut1 (
        .CLK(clk), .nRST(nrst), .UP(up), .KEEP(keep), .TRIG(trig),
        .OUT(out_o[1]), .TC(tc_o[1]), .BUSY(busy_o[1]), .POUT(pout1));

    gp_count_fsm #(.WIDTH(3), .POUT_WIDTH(3), .COUNT_TO(7), .RESET_VALUE("COUNT_TO"),
                   .CLKIN_DIVIDE(1), .MODE("REPEAT")) u_dut2 (
        .CLK(clk), .nRST(nrst), .UP(up), .KEEP(keep), .TRIG(trig),
        .OUT(out_o[2]), .TC(tc_o[2]), .BUSY(busy_o[2]), .POUT(pout2));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int terminal(input int i, input logic dir_up);
        return dir_up ? (1 << P_W[i]) - 1 : 0;
    endfunction

    task automatic model_reset(input int i);
        m_cnt[i] = (P_RVC[i] != 0) ? P_CT[i] : 0;
        m_div[i] = 0;
        m_tc[i]  = 0;
        m_st[i]  = (P_ONE[i] != 0) ? S_IDLE : S_RUN;
    endtask

    // Advance every model by one rising CLK using the inputs currently applied.
    task automatic model_step();
        int modulus;
        for (int i = 0; i < NI; i++) begin
            modulus = 1 << P_W[i];
            m_tc[i] = 0;
            if (!nrst) begin
                model_reset(i);
            end else if (P_ONE[i] != 0 && m_st[i] != S_RUN) begin
                if (trig) begin
                    m_st[i]  = S_RUN;
                    m_cnt[i] = P_CT[i] % modulus;
                    m_div[i] = 0;
                end
            end else if (!keep) begin
                if (m_div[i] == P_DIV[i] - 1) begin
                    m_div[i] = 0;
                    if (m_cnt[i] == terminal(i, up)) begin
                        m_tc[i] = 1;
                        if (P_ONE[i] != 0) m_st[i] = S_DONE;
                        else               m_cnt[i] = P_CT[i] % modulus;
                    end else begin
                        m_cnt[i] = (m_cnt[i] + (up ? 1 : -1) + modulus) % modulus;
                    end
                end else begin
                    m_div[i] = m_div[i] + 1;
                end
            end
        end
    endtask

    task automatic check_all(input int cyc);
        int exp_out;
        int pout_act;
        for (int i = 0; i < NI; i++) begin
            if (P_ONE[i] != 0 && m_st[i] == S_IDLE)      exp_out = 0;
            else if (P_ONE[i] != 0 && m_st[i] == S_DONE) exp_out = 1;
            else                                         exp_out = (m_cnt[i] == terminal(i, up)) ? 1 : 0;
            case (i)
                0:       pout_act = int'(pout0);
                1:       pout_act = int'(pout1);
                default: pout_act = int'(pout2);
            endcase
            chk($sformatf("c%0d_i%0d_out", cyc, i),  32'(out_o[i]),  32'(exp_out));
            chk($sformatf("c%0d_i%0d_tc", cyc, i),   32'(tc_o[i]),   32'(m_tc[i]));
            chk($sformatf("c%0d_i%0d_busy", cyc, i), 32'(busy_o[i]), 32'((m_st[i] == S_RUN) ? 1 : 0));
            chk($sformatf("c%0d_i%0d_pout", cyc, i), 32'(pout_act),  32'(m_cnt[i] % (1 << P_PW[i])));
        end
    endtask

    initial begin
        nrst = 1'b0;
        up   = 1'b0;
        keep = 1'b0;
        trig = 1'b0;
        for (int i = 0; i < NI; i++) model_reset(i);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) up = ~up;
            keep = ($urandom_range(0, 4) == 0);
            trig = ($urandom_range(0, 7) == 0);
            nrst = (cyc < 3) ? 1'b0 : ($urandom_range(0, 89) != 0);
            // Reset is asynchronous: the model must reflect it before the next edge.
            if (!nrst) begin
                for (int i = 0; i < NI; i++) model_reset(i);
            end
            #1;
            check_all(cyc);
            @(posedge clk);
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
